// File: rtl/ysyx_24080006_icache_ctrl.sv
// Direct-mapped I-cache controller: SRAM lookup, single-burst AXI line refill, and fence.i index walk.
// Optional hit/miss counters (perf_hit/perf_miss) are enabled by defining ICACHE_PERF_EN.
module ysyx_24080006_icache_ctrl #(
    parameter  int IC_N       = 4,
    parameter  int LINE_WORDS = 4,
    localparam int OFS        = $clog2(LINE_WORDS * 4),
    localparam int TAG_W      = 32 - IC_N - OFS,
    localparam int ENT_W      = 1 + TAG_W + 32 * LINE_WORDS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    input  logic             flush,
    output logic             flush_done,
    output logic [IC_N-1:0]  ic_index,
    input  logic [ENT_W-1:0] ic_rdata,
    output logic             ic_we,
    output logic [ENT_W-1:0] ic_wdata,
    output logic             arvalid,
    input  logic             arready,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    input  logic             rvalid,
    output logic             rready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]      perf_hit,
    output logic [31:0]      perf_miss
`endif
);
    localparam int WW = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_FILL, S_RESP, S_FLUSH} state_e;

    state_e                       state_q, state_d;
    logic [31:0]                  addr_q, addr_d;
    logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
    logic [WW-1:0]                cnt_q, cnt_d;
    logic [IC_N-1:0]              fcnt_q, fcnt_d;
    logic                         err_q, err_d;
    logic                         pend_q, pend_d;
    logic [31:0]                  rsp_data_q, rsp_data_d;
    logic                         rsp_err_q, rsp_err_d;
    logic                         done_q, done_d;

    logic [TAG_W-1:0]             addr_tag;
    logic [IC_N-1:0]              addr_idx;
    logic [WW-1:0]                addr_word;
    logic [LINE_WORDS-1:0][31:0]  sram_line;
    logic                         hit;
    logic [1:0]                   unused_addr;

    assign addr_tag    = addr_q[31 -: TAG_W];
    assign addr_idx    = addr_q[OFS +: IC_N];
    assign addr_word   = addr_q[OFS-1:2];
    assign unused_addr = addr_q[1:0];
    assign sram_line   = ic_rdata[32*LINE_WORDS-1:0];
    assign hit         = ic_rdata[ENT_W-1] && (ic_rdata[32*LINE_WORDS +: TAG_W] == addr_tag);

    assign resp_data  = rsp_data_q;
    assign resp_err   = rsp_err_q;
    assign flush_done = done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        err_d      = err_q;
        pend_d     = pend_q | (flush && state_q != S_IDLE);
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        done_d     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ic_we      = 1'b0;
        ic_wdata   = '0;
        ic_index   = '0;
        arvalid    = 1'b0;
        araddr     = '0;
        arlen      = '0;
        arsize     = '0;
        arburst    = '0;
        rready     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending or fresh fence.i blocks new fetches until the walk is done.
                if (flush || pend_q) begin
                    state_d = S_FLUSH;
                    pend_d  = 1'b0;
                    fcnt_d  = '0;
                end else begin
                    req_ready = reset;
                    if (req_valid) begin
                        addr_d  = req_addr;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                ic_index = addr_idx;
                if (hit) begin
                    rsp_data_d = sram_line[addr_word];
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                araddr  = {addr_q[31:OFS], {OFS{1'b0}}};
                arlen   = 8'(LINE_WORDS - 1);
                arsize  = 3'b010;
                arburst = 2'b01;
                if (arready) begin
                    state_d = S_R;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    line_d[cnt_q] = rdata;
                    cnt_d         = cnt_q + 1'b1;
                    if (rresp != 2'b00) err_d = 1'b1;
                    if (rlast) begin
                        // A faulty line is never installed; the fetch just reports the error.
                        if (err_q || rresp != 2'b00) begin
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                            state_d    = S_RESP;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                ic_we      = 1'b1;
                ic_index   = addr_idx;
                ic_wdata   = {1'b1, addr_tag, line_q};
                rsp_data_d = line_q[addr_word];
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = S_IDLE;
            end
            S_FLUSH: begin
                ic_we    = 1'b1;
                ic_index = fcnt_q;
                fcnt_d   = fcnt_q + 1'b1;
                if (fcnt_q == '1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            done_q     <= done_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit) begin
                if (perf_hit_q != '1) perf_hit_q <= perf_hit_q + 32'd1;
            end else begin
                if (perf_miss_q != '1) perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif

endmodule
